// File: rtl/mpq_feeder_if.sv
// Signal bundle between host, mpq_feeder and the max-priority-queue core.
// slave = feeder view; master = environment (host + core) view.
interface mpq_feeder_if;
   logic       h_data_valid;
   logic [7:0] h_data;
   logic       h_data_ready;
   logic       h_cmd_valid;
   logic [2:0] h_cmd;
   logic [7:0] h_index;
   logic [7:0] h_value;
   logic       h_cmd_ready;
   logic       mpq_rst;
   logic       data_valid;
   logic [7:0] data;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic [7:0] index;
   logic [7:0] value;
   logic       busy;
   logic       done;
   logic       session;
   logic       err;

   modport slave (
      input  h_data_valid, h_data, h_cmd_valid, h_cmd, h_index, h_value, busy, done,
      output h_data_ready, h_cmd_ready, mpq_rst, data_valid, data,
             cmd_valid, cmd, index, value, session, err
   );

   modport master (
      output h_data_valid, h_data, h_cmd_valid, h_cmd, h_index, h_value, busy, done,
      input  h_data_ready, h_cmd_ready, mpq_rst, data_valid, data,
             cmd_valid, cmd, index, value, session, err
   );
endinterface

// File: rtl/mpq_feeder.sv
// Host-side feeder for the max-priority-queue core: 12-byte load burst plus queued commands.
// Optional MPQ_GUARD_EN drops commands that would under/overflow the core heap.
module mpq_feeder #(
   parameter int CMD_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   mpq_feeder_if.slave bus
);

   localparam int AW = $clog2(CMD_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(CMD_DEPTH);

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_BURST = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_ACK   = 3'd4,
      ST_DRAIN = 3'd5
   } state_t;

   state_t      state_r, state_nxt_s;

   logic [7:0]  load_buf_r [12];
   logic [3:0]  wptr_r;
   logic [3:0]  bidx_r, bidx_nxt_s;
   logic        wptr_clr_s;
   logic        accept_s;
   logic        h_data_ready_s;

   logic [18:0] fifo_mem_r [CMD_DEPTH];
   logic [AW-1:0] rd_ptr_r, wr_ptr_r;
   logic [CW-1:0] fifo_cnt_r;
   logic        full_s, empty_s, push_s, store_s, pop_s;
   logic [18:0] head_s;

   logic [4:0]  hcnt_r, hcnt_nxt_s;
   logic        drop_s;

   logic        mpq_rst_r, mpq_rst_nxt_s;
   logic        data_valid_r, data_valid_nxt_s;
   logic [7:0]  data_r, data_nxt_s;
   logic        cmd_valid_r, cmd_valid_nxt_s;
   logic [2:0]  cmd_r, cmd_nxt_s;
   logic [7:0]  index_r, index_nxt_s;
   logic [7:0]  value_r, value_nxt_s;
   logic        session_r, session_nxt_s;
   logic        err_r, err_nxt_s;

`ifdef MPQ_GUARD_EN
   function automatic logic guard_drop(input logic [2:0] op, input logic [7:0] idx,
                                       input logic [4:0] cnt);
      case (op)
         3'd1:    return (cnt == 5'd0);
         3'd2:    return (idx >= {3'b000, cnt});
         3'd3:    return (cnt == 5'd16);
         default: return 1'b0;
      endcase
   endfunction

   assign drop_s = guard_drop(head_s[18:16], head_s[15:8], hcnt_r);
`else
   assign drop_s = 1'b0;
`endif

   assign h_data_ready_s = (state_r == ST_LOAD) && (wptr_r < 4'd12);
   assign accept_s       = bus.h_data_valid && h_data_ready_s;

   assign full_s  = (fifo_cnt_r == FULL_CNT);
   assign empty_s = (fifo_cnt_r == CW'(0));
   assign push_s  = bus.h_cmd_valid && !full_s;
   // Reserved opcodes complete the handshake but never reach the queue.
   assign store_s = push_s && (bus.h_cmd <= 3'd4);
   assign head_s  = fifo_mem_r[rd_ptr_r];

   // Load buffer capture and write pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_r <= 4'd0;
         for (int i = 0; i < 12; i++) begin
            load_buf_r[i] <= 8'd0;
         end
      end else if (wptr_clr_s) begin
         wptr_r <= 4'd0;
      end else if (accept_s) begin
         load_buf_r[wptr_r] <= bus.h_data;
         wptr_r             <= wptr_r + 4'd1;
      end
   end

   // Command FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_r   <= '0;
         wr_ptr_r   <= '0;
         fifo_cnt_r <= '0;
         for (int i = 0; i < CMD_DEPTH; i++) begin
            fifo_mem_r[i] <= 19'd0;
         end
      end else begin
         if (store_s) begin
            fifo_mem_r[wr_ptr_r] <= {bus.h_cmd, bus.h_index, bus.h_value};
            wr_ptr_r             <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({store_s, pop_s})
            2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
            2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
            default: fifo_cnt_r <= fifo_cnt_r;
         endcase
      end
   end

   // FSM state, burst index and heap-count registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_LOAD;
         bidx_r  <= 4'd0;
         hcnt_r  <= 5'd0;
      end else begin
         state_r <= state_nxt_s;
         bidx_r  <= bidx_nxt_s;
         hcnt_r  <= hcnt_nxt_s;
      end
   end

   // Next state and next values of all registered core-side outputs.
   always_comb begin
      state_nxt_s      = state_r;
      bidx_nxt_s       = bidx_r;
      hcnt_nxt_s       = hcnt_r;
      wptr_clr_s       = 1'b0;
      pop_s            = 1'b0;
      mpq_rst_nxt_s    = mpq_rst_r;
      data_valid_nxt_s = 1'b0;
      data_nxt_s       = 8'd0;
      cmd_valid_nxt_s  = 1'b0;
      cmd_nxt_s        = 3'd7;
      index_nxt_s      = index_r;
      value_nxt_s      = value_r;
      session_nxt_s    = session_r;
      err_nxt_s        = 1'b0;

      case (state_r)
         ST_LOAD: begin
            // First burst byte leaves in the same cycle the core comes out of reset.
            if (wptr_r == 4'd12) begin
               state_nxt_s      = ST_BURST;
               mpq_rst_nxt_s    = 1'b0;
               data_valid_nxt_s = 1'b1;
               data_nxt_s       = load_buf_r[0];
               bidx_nxt_s       = 4'd1;
               hcnt_nxt_s       = 5'd12;
               session_nxt_s    = 1'b1;
            end else begin
               mpq_rst_nxt_s    = 1'b1;
            end
         end
         ST_BURST: begin
            if (bidx_r == 4'd12) begin
               state_nxt_s = ST_WAIT;
               bidx_nxt_s  = 4'd0;
               wptr_clr_s  = 1'b1;
            end else begin
               data_valid_nxt_s = 1'b1;
               data_nxt_s       = load_buf_r[bidx_r];
               bidx_nxt_s       = bidx_r + 4'd1;
            end
         end
         ST_WAIT: begin
            if (!bus.busy && !empty_s) begin
               pop_s = 1'b1;
               if (drop_s) begin
                  err_nxt_s = 1'b1;
               end else begin
                  state_nxt_s     = ST_ISSUE;
                  cmd_valid_nxt_s = 1'b1;
                  cmd_nxt_s       = head_s[18:16];
                  index_nxt_s     = head_s[15:8];
                  value_nxt_s     = head_s[7:0];
                  case (head_s[18:16])
                     3'd1:    hcnt_nxt_s = hcnt_r - 5'd1;
                     3'd3:    hcnt_nxt_s = hcnt_r + 5'd1;
                     default: hcnt_nxt_s = hcnt_r;
                  endcase
               end
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_ISSUE: begin
            if (cmd_r == 3'd4) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_ACK;
            end
         end
         ST_ACK: begin
            if (bus.busy) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_ACK;
            end
         end
         ST_DRAIN: begin
            if (bus.done) begin
               state_nxt_s   = ST_LOAD;
               mpq_rst_nxt_s = 1'b1;
               session_nxt_s = 1'b0;
            end else begin
               state_nxt_s   = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s   = ST_LOAD;
            mpq_rst_nxt_s = 1'b1;
            session_nxt_s = 1'b0;
         end
      endcase
   end

   // Registered core-side and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mpq_rst_r    <= 1'b1;
         data_valid_r <= 1'b0;
         data_r       <= 8'd0;
         cmd_valid_r  <= 1'b0;
         cmd_r        <= 3'd7;
         index_r      <= 8'd0;
         value_r      <= 8'd0;
         session_r    <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         mpq_rst_r    <= mpq_rst_nxt_s;
         data_valid_r <= data_valid_nxt_s;
         data_r       <= data_nxt_s;
         cmd_valid_r  <= cmd_valid_nxt_s;
         cmd_r        <= cmd_nxt_s;
         index_r      <= index_nxt_s;
         value_r      <= value_nxt_s;
         session_r    <= session_nxt_s;
         err_r        <= err_nxt_s;
      end
   end

   assign bus.h_data_ready = h_data_ready_s;
   assign bus.h_cmd_ready  = !full_s;
   assign bus.mpq_rst      = mpq_rst_r;
   assign bus.data_valid   = data_valid_r;
   assign bus.data         = data_r;
   assign bus.cmd_valid    = cmd_valid_r;
   assign bus.cmd          = cmd_r;
   assign bus.index        = index_r;
   assign bus.value        = value_r;
   assign bus.session      = session_r;
   assign bus.err          = err_r;

endmodule

// File: tb/tb_mpq_feeder.sv
// Directed table-driven bench for mpq_feeder with a small busy/done core model.
// Expected results for the guarded build follow MPQ_GUARD_EN.
module tb_mpq_feeder;

   logic clk = 1'b0;
   logic rst;

   mpq_feeder_if bus ();

   mpq_feeder #(.CMD_DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dv;
      logic [7:0]  d;
      logic        cv;
      logic [2:0]  c;
      logic        busy;
      logic [17:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [18:0] push_q[$];
   logic [18:0] issued_q[$];
   logic [18:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          err_cnt  = 0;
   int          mdl_cnt  = 0;
   bit          mdl_wo   = 1'b0;

   function automatic logic [17:0] pack_exp(input logic mr, input logic dv, input logic [7:0] d,
                                            input logic cv, input logic [2:0] c, input logic ses,
                                            input logic er, input logic hdr, input logic hcr);
      return {mr, dv, d, cv, c, ses, er, hdr, hcr};
   endfunction

   function automatic logic [17:0] observed();
      return {bus.mpq_rst, bus.data_valid, bus.data, bus.cmd_valid, bus.cmd,
              bus.session, bus.err, bus.h_data_ready, bus.h_cmd_ready};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.h_data_valid = 1'b0;
      bus.h_data       = 8'd0;
      bus.h_cmd_valid  = 1'b0;
      bus.h_cmd        = 3'd0;
      bus.h_index      = 8'd0;
      bus.h_value      = 8'd0;
      bus.done         = 1'b0;
   endtask

   task automatic add_vec(input logic dv, input logic [7:0] d, input logic cv,
                          input logic [2:0] c, input logic busy, input logic [17:0] exp);
      vec_t v;
      v.dv = dv; v.d = d; v.cv = cv; v.c = c; v.busy = busy; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic load_bytes(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         bus.h_data_valid = 1'b1;
         bus.h_data       = base + 8'(i);
         tick();
      end
      bus.h_data_valid = 1'b0;
   endtask

   // Core model: busy for 3 cycles after each command; write-out ends with a done pulse.
   task automatic run_core(input int max_cycles, input bit stop_on_restart);
      bit restarted = 1'b0;
      logic busy_s, done_s;
      logic [18:0] e;
      for (int i = 0; i < max_cycles && !restarted; i++) begin
         if (push_q.size() > 0) begin
            e = push_q.pop_front();
            bus.h_cmd_valid = 1'b1;
            bus.h_cmd       = e[18:16];
            bus.h_index     = e[15:8];
            bus.h_value     = e[7:0];
         end else begin
            bus.h_cmd_valid = 1'b0;
         end
         busy_s = bus.busy;
         done_s = bus.done;
         tick();
         bus.done = 1'b0;
         if (done_s) begin
            check("restart_mpq_rst", 32'(bus.mpq_rst), 32'd1);
            check("restart_session", 32'(bus.session), 32'd0);
            restarted = 1'b1;
         end
         if (bus.err) begin
            err_cnt++;
            check("err_without_issue", 32'(bus.cmd_valid), 32'd0);
         end
         if (bus.cmd_valid) begin
            issued_q.push_back({bus.cmd, bus.index, bus.value});
            check("issue_while_busy", 32'(busy_s), 32'd0);
            bus.busy = 1'b1;
            mdl_cnt  = 3;
            mdl_wo   = (bus.cmd == 3'd4);
         end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
               if (mdl_wo) bus.done = 1'b1;
               else        bus.busy = 1'b0;
            end
         end
      end
      bus.h_cmd_valid = 1'b0;
      if (stop_on_restart) check("restart_seen", 32'(restarted), 32'd1);
   endtask

   initial begin
      int cv_seen;
      rst = 1'b0;
      idle_inputs();
      bus.busy = 1'b1;

      // Session 1 load with one early build command, then its issue.
      for (int t = 1; t <= 12; t++)
         add_vec(1'b1, 8'(t), (t == 1), 3'd0, 1'b1, pack_exp(1'b1, 1'b0, 8'd0, 1'b0, 3'd7, 1'b0, 1'b0, (t < 12), 1'b1));
      for (int k = 0; k < 12; k++)
         add_vec(1'b0, 8'd0, 1'b0, 3'd0, 1'b1, pack_exp(1'b0, 1'b1, 8'(k + 1), 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1));
      add_vec(1'b0, 8'd0, 1'b0, 3'd0, 1'b1, pack_exp(1'b0, 1'b0, 8'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1));
      add_vec(1'b0, 8'd0, 1'b0, 3'd0, 1'b0, pack_exp(1'b0, 1'b0, 8'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1));
      add_vec(1'b0, 8'd0, 1'b0, 3'd0, 1'b1, pack_exp(1'b0, 1'b0, 8'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1));
      add_vec(1'b0, 8'd0, 1'b0, 3'd0, 1'b1, pack_exp(1'b0, 1'b0, 8'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1));
      add_vec(1'b0, 8'd0, 1'b0, 3'd0, 1'b0, pack_exp(1'b0, 1'b0, 8'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1));

      tick();
      tick();
      check("reset_outputs", 32'(observed()), 32'(pack_exp(1'b1, 1'b0, 8'd0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1)));
      check("reset_index_value", {16'd0, bus.index, bus.value}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.h_data_valid = vecs[i].dv;
         bus.h_data       = vecs[i].d;
         bus.h_cmd_valid  = vecs[i].cv;
         bus.h_cmd        = vecs[i].c;
         bus.busy         = vecs[i].busy;
         tick();
         check($sformatf("vec%0d", i), 32'(observed()), 32'(vecs[i].exp));
      end
      idle_inputs();

      // Build, insert 200, write-out back-to-back against the core model.
      push_q.push_back({3'd0, 8'd0, 8'd0});
      push_q.push_back({3'd3, 8'd0, 8'd200});
      push_q.push_back({3'd4, 8'd0, 8'd0});
      mdl_cnt = 0;
      run_core(100, 1'b1);
      check("b2b_issue_count", 32'(issued_q.size()), 32'd3);
      check("b2b_issue0", 32'(issued_q[0]), 32'({3'd0, 8'd0, 8'd0}));
      check("b2b_issue1", 32'(issued_q[1]), 32'({3'd3, 8'd0, 8'd200}));
      check("b2b_issue2", 32'(issued_q[2]), 32'({3'd4, 8'd0, 8'd0}));
      check("restart_data_ready", 32'(bus.h_data_ready), 32'd1);

      // Fill the FIFO during LOAD, then run session 2.
      issued_q.delete();
      err_cnt  = 0;
      bus.busy = 1'b1;
      exp_q = '{{3'd3, 8'd0, 8'd10}, {3'd3, 8'd0, 8'd11}, {3'd3, 8'd0, 8'd12}, {3'd3, 8'd0, 8'd13},
                {3'd3, 8'd0, 8'd14}, {3'd2, 8'd3, 8'd50}, {3'd1, 8'd0, 8'd0}, {3'd0, 8'd0, 8'd0}};
      for (int i = 0; i < 8; i++) begin
         bus.h_cmd_valid = 1'b1;
         bus.h_cmd       = exp_q[i][18:16];
         bus.h_index     = exp_q[i][15:8];
         bus.h_value     = exp_q[i][7:0];
         tick();
         if (i == 6) check("ready_before_full", 32'(bus.h_cmd_ready), 32'd1);
      end
      check("ready_when_full", 32'(bus.h_cmd_ready), 32'd0);
      bus.h_cmd   = 3'd4;
      bus.h_index = 8'd0;
      bus.h_value = 8'd0;
      tick();
      bus.h_cmd_valid = 1'b0;
      check("ready_after_9th", 32'(bus.h_cmd_ready), 32'd0);
      load_bytes(8'h30, 12);
      tick();
      check("burst2_first", {22'd0, bus.mpq_rst, bus.data_valid, bus.data}, {22'd0, 1'b0, 1'b1, 8'h30});
      for (int i = 0; i < 11; i++) tick();
      check("burst2_last", {23'd0, bus.data_valid, bus.data}, {23'd0, 1'b1, 8'h3B});
      tick();
      bus.busy = 1'b0;
      tick();
      check("ready_after_pop", 32'(bus.h_cmd_ready), 32'd1);
      check("first_pop_cmd_valid", 32'(bus.cmd_valid), 32'd1);
      if (bus.cmd_valid) issued_q.push_back({bus.cmd, bus.index, bus.value});
      bus.busy = 1'b1;
      mdl_cnt  = 3;
      mdl_wo   = 1'b0;
      run_core(80, 1'b0);
`ifdef MPQ_GUARD_EN
      exp_q.delete(4);
      check("guard_err_pulses", 32'(err_cnt), 32'd1);
`else
      check("guard_err_pulses", 32'(err_cnt), 32'd0);
`endif
      check("fill_issue_count", 32'(issued_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("fill_issue%0d", i), 32'(issued_q[i]), 32'(exp_q[i]));

      // Reset mid-burst at byte 6.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      bus.busy = 1'b1;
      bus.h_cmd_valid = 1'b1;
      bus.h_cmd       = 3'd0;
      tick();
      bus.h_cmd_valid = 1'b0;
      load_bytes(8'h50, 12);
      for (int i = 0; i < 7; i++) tick();
      check("mid_burst_byte6", 32'(bus.data), 32'h56);
      #1 rst = 1'b0;
      #1;
      check("midreset_outputs", 32'(observed()), 32'(pack_exp(1'b1, 1'b0, 8'd0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1)));
      check("midreset_index_value", {16'd0, bus.index, bus.value}, 32'd0);
      tick();
      rst = 1'b1;
      load_bytes(8'h70, 11);
      check("ptr_cleared_11_bytes", {30'd0, bus.mpq_rst, bus.h_data_ready}, {30'd0, 1'b1, 1'b1});
      tick();
      check("no_early_burst", 32'(bus.mpq_rst), 32'd1);
      load_bytes(8'h7B, 1);
      tick();
      check("post_reset_burst", {22'd0, bus.mpq_rst, bus.data_valid, bus.data}, {22'd0, 1'b0, 1'b1, 8'h70});
      for (int i = 0; i < 12; i++) tick();
      bus.busy = 1'b0;
      cv_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.cmd_valid) cv_seen++;
      end
      check("fifo_empty_after_reset", 32'(cv_seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
